// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Constants and FSM encoding shared by the SHA-256 message scheduler
//   and its helpers.
//   - WORD_W / BLOCK_W / NUM_ROUNDS / BUF_DEPTH : fixed SHA-256 geometry
//   - state_t and IDLE..DONE                   : scheduler FSM encoding
//   - byte_swap32                              : little-endian bus helper
package sha256_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLOCK_W    = 512;
    localparam int unsigned NUM_ROUNDS = 64;
    localparam int unsigned BUF_DEPTH  = 16;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t READY = 3'd2;
    localparam state_t CALC1 = 3'd3;
    localparam state_t CALC2 = 3'd4;
    localparam state_t CALC3 = 3'd5;
    localparam state_t DONE  = 3'd6;

    // Reverses the byte order of one word.
    function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// adder_32bit
//   Plain 32-bit modular adder; the carry out is discarded.
//   Ports: a, b (operands), sum (a + b mod 2^32).
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/sigma_func_schedule.sv
// sigma_func_schedule
//   Combinational SHA-256 message-schedule sigma functions.
//   Ports: x (input word), s0 = ROTR7^ROTR18^SHR3, s1 = ROTR17^ROTR19^SHR10.
module sigma_func_schedule
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    assign s0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    assign s1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);

endmodule

// File: rtl/message_scheduler.sv
// message_scheduler
//   Captures one 512-bit padded block and hands out the SHA-256 schedule
//   words W0..W63 one at a time on a valid/next handshake. W16..W63 are
//   built in place in a 16-word circular buffer with one shared adder over
//   three cycles (CALC1..CALC3).
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     load, block_in  capture a block and restart at t=0 (load beats next)
//     next            consumer has used the current word
//     wt_out,wt_valid current word W_t and its valid flag
//     t_index         index t of the current word
//     busy, done      schedule in progress / one-cycle end pulse
//   Build option: MSG_SCHED_BYTE_SWAP_EN byte-reverses each block word on
//   capture (little-endian bus); timing is unchanged.
module message_scheduler
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [BLOCK_W-1:0] block_in,
    input  logic               next,
    output logic [WORD_W-1:0]  wt_out,
    output logic               wt_valid,
    output logic [5:0]         t_index,
    output logic               busy,
    output logic               done
);

    localparam logic [5:0] LAST_T   = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] LAST_RAW = 6'(BUF_DEPTH - 1);

    state_t            state_q, state_d;
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] w_q [BUF_DEPTH];

    // Index of the word being generated; t does not move during CALC.
    logic [5:0] n;
    logic [3:0] slot_n, slot_m2, slot_m7, slot_m15;

    assign n        = t_q + 6'd1;
    assign slot_n   = n[3:0];
    assign slot_m2  = slot_n - 4'd2;
    assign slot_m7  = slot_n - 4'd7;
    assign slot_m15 = slot_n - 4'd15;

    // Block words in W order, optionally byte-reversed.
    logic [WORD_W-1:0] blk_word [BUF_DEPTH];

    for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_word
        logic [WORD_W-1:0] raw;
        assign raw = block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
`ifdef MSG_SCHED_BYTE_SWAP_EN
        assign blk_word[i] = byte_swap32(raw);
`else
        assign blk_word[i] = raw;
`endif
    end

    // Shared sigma unit and adder, operands picked by state only.
    logic [WORD_W-1:0] sigma_x, s0, s1;
    logic [WORD_W-1:0] add_a, add_b, add_sum;

    always_comb begin
        sigma_x = '0;
        case (state_q)
            CALC1:   sigma_x = w_q[slot_m2];
            CALC2:   sigma_x = w_q[slot_m15];
            default: sigma_x = '0;
        endcase
    end

    sigma_func_schedule u_sigma (
        .x  (sigma_x),
        .s0 (s0),
        .s1 (s1)
    );

    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_q)
            CALC1: begin
                add_a = s1;
                add_b = w_q[slot_m7];
            end
            CALC2: begin
                add_a = acc_q;
                add_b = s0;
            end
            CALC3: begin
                // Slot n still holds W_{n-16}, the last term of the sum.
                add_a = acc_q;
                add_b = w_q[slot_n];
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    adder_32bit u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    // Next-state logic. load overrides everything, including a pending CALC3.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        acc_d   = acc_q;
        if (load) begin
            state_d = LOAD;
            t_d     = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    t_d     = '0;
                    state_d = READY;
                end
                READY: begin
                    if (next) begin
                        if (t_q < LAST_RAW) begin
                            t_d = t_q + 6'd1;
                        end else if (t_q == LAST_T) begin
                            state_d = DONE;
                        end else begin
                            state_d = CALC1;
                        end
                    end
                end
                CALC1: begin
                    acc_d   = add_sum;
                    state_d = CALC2;
                end
                CALC2: begin
                    acc_d   = add_sum;
                    state_d = CALC3;
                end
                CALC3: begin
                    t_d     = n;
                    state_d = READY;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
        end
    end

    // The block is captured on the edge that accepts load, so block_in only
    // needs to be valid alongside load; the LOAD cycle then exposes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                w_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                w_q[i] <= blk_word[i];
            end
        end else if (state_q == CALC3) begin
            w_q[slot_n] <= add_sum;
        end
    end

    assign wt_out   = w_q[t_q[3:0]];
    assign wt_valid = (state_q == READY);
    assign t_index  = t_q;
    assign busy     = (state_q == LOAD) || (state_q == READY) || (state_q == CALC1) ||
                      (state_q == CALC2) || (state_q == CALC3);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_message_scheduler.sv
// tb_message_scheduler
//   Self-checking bench for message_scheduler. A reference model computes
//   W0..W63 directly from the SHA-256 recurrence; a table holds the known
//   "abc" words; hand sequences cover streaming, load-during-CALC,
//   load+next, next during CALC and reset mid-calculation.
//   Honours MSG_SCHED_BYTE_SWAP_EN the same way as the design.
module tb_message_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [511:0] block_in;
    logic         next;
    logic [31:0]  wt_out;
    logic         wt_valid;
    logic [5:0]   t_index;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    message_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .block_in (block_in),
        .next     (next),
        .wt_out   (wt_out),
        .wt_valid (wt_valid),
        .t_index  (t_index),
        .busy     (busy),
        .done     (done)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_w [64];

    typedef struct {
        int          idx;
        logic [31:0] w;
    } vec_t;

    vec_t abc_tab [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Converts between logical W order and the bus representation.
    function automatic logic [31:0] bus_word(input logic [31:0] w);
`ifdef MSG_SCHED_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic void model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = bus_word(blk[511 - 32*i -: 32]);
        end
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
        end
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[511 - 32*i -: 32] = $urandom();
        end
        return b;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads blk (optionally with next in the same cycle) and checks t=0 is
    // presented two cycles after load is raised.
    task automatic do_load(input logic [511:0] blk, input bit with_next);
        model(blk);
        block_in = blk;
        load     = 1'b1;
        next     = with_next;
        tick();
        load = 1'b0;
        next = 1'b0;
        check("load_cycle_valid", wt_valid, 1'b0);
        tick();
        check("load_valid", wt_valid, 1'b1);
        check("load_t_index", t_index, 0);
        check("load_w0", wt_out, exp_w[0]);
    endtask

    // Consumes words t_from..t_to, checking values, indices and latency.
    task automatic walk(input int t_from, input int t_to, input bit noise, input bit gaps);
        for (int t = t_from; t <= t_to; t++) begin
            int lat;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) tick();
            end
            check("word_valid", wt_valid, 1'b1);
            check("word_t_index", t_index, t);
            check($sformatf("W%0d", t), wt_out, exp_w[t]);
            check("word_busy", busy, 1'b1);
            next = 1'b1;
            tick();
            next = 1'b0;
            if (t == 63) begin
                check("done_pulse", done, 1'b1);
                check("done_busy", busy, 1'b0);
                check("done_valid", wt_valid, 1'b0);
                tick();
                check("done_clear", done, 1'b0);
                check("idle_busy", busy, 1'b0);
            end else begin
                lat = 1;
                while (!wt_valid && lat < 8) begin
                    // next here must be ignored and t must hold.
                    check("calc_t_hold", t_index, t);
                    check("calc_done_low", done, 1'b0);
                    if (noise) next = 1'($urandom_range(0, 1));
                    tick();
                    lat++;
                end
                next = 1'b0;
                check($sformatf("latency_W%0d", t + 1), lat, (t < 15) ? 1 : 4);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [511:0] abc_blk;
        logic [511:0] blk;
        int accepted, done_cnt, ticks, done_tick, zero_bad;
        logic v;

        abc_tab[0] = '{0,  32'h61626380};
        abc_tab[1] = '{15, 32'h00000018};
        abc_tab[2] = '{16, 32'h61626380};
        abc_tab[3] = '{17, 32'h000f0000};
        abc_tab[4] = '{18, 32'h7da86405};
        abc_tab[5] = '{19, 32'h600003c6};

        abc_blk = {bus_word(32'h61626380), 448'h0, bus_word(32'h00000018)};

        rst_n    = 1'b0;
        load     = 1'b0;
        next     = 1'b0;
        block_in = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_wt_valid", wt_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_t_index", t_index, 0);
        check("rst_wt_out", wt_out, 32'h0);

        // next in IDLE does nothing
        next = 1'b1;
        tick();
        next = 1'b0;
        check("idle_next_t", t_index, 0);
        check("idle_next_valid", wt_valid, 1'b0);

        // "abc" block, table-driven known words
        do_load(abc_blk, 1'b0);
        walk(0, 63, 1'b0, 1'b0);
        model(abc_blk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abc_W%0d_model", abc_tab[i].idx), exp_w[abc_tab[i].idx],
                  abc_tab[i].w);
        end

        // Replay abc with the table checked directly on the live outputs.
        do_load(abc_blk, 1'b0);
        for (int i = 0; i < 6; i++) begin
            int guard;
            guard = 0;
            while ((!wt_valid || int'(t_index) != abc_tab[i].idx) && guard < 100) begin
                if (wt_valid) next = 1'b1;
                tick();
                next = 1'b0;
                guard++;
            end
            check($sformatf("abc_tab_idx%0d", abc_tab[i].idx), t_index, abc_tab[i].idx);
            check($sformatf("abc_tab_W%0d", abc_tab[i].idx), wt_out, abc_tab[i].w);
        end

        // All-zero block, next held high throughout
        do_load('0, 1'b0);
        accepted  = 0;
        done_cnt  = 0;
        ticks     = 0;
        done_tick = -1;
        zero_bad  = 0;
        next      = 1'b1;
        while (ticks < 400 && done_cnt == 0) begin
            v = wt_valid;
            if (v && wt_out !== 32'h0) zero_bad++;
            tick();
            ticks++;
            if (v) accepted++;
            if (done) begin
                done_cnt++;
                done_tick = ticks;
                check("stream_done_busy", busy, 1'b0);
                check("stream_done_after_accept", v, 1'b1);
            end
        end
        repeat (3) begin
            tick();
            if (done) done_cnt++;
        end
        next = 1'b0;
        check("stream_zero_words", zero_bad, 0);
        check("stream_accepted", accepted, 64);
        check("stream_done_pulses", done_cnt, 1);
        check("stream_done_cycle", done_tick, 16 + 48 * 4);

        // load during CALC2 of word 20
        do_load(abc_blk, 1'b0);
        walk(0, 18, 1'b1, 1'b1);
        check("pre_calc_t", t_index, 19);
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        check("in_calc2_valid", wt_valid, 1'b0);
        blk = rand_block();
        do_load(blk, 1'b0);
        walk(0, 63, 1'b1, 1'b1);

        // load and next together: load wins
        do_load(rand_block(), 1'b0);
        walk(0, 4, 1'b0, 1'b0);
        do_load(rand_block(), 1'b1);
        walk(0, 63, 1'b0, 1'b0);

        // Random blocks with random gaps and ignored next pulses
        repeat (3) begin
            do_load(rand_block(), 1'b0);
            walk(0, 63, 1'b1, 1'b1);
        end

        // Reset in the middle of a calculation
        do_load(rand_block(), 1'b0);
        walk(0, 16, 1'b0, 1'b0);
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", wt_valid, 1'b0);
        check("midrst_t_index", t_index, 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_wt_out", wt_out, 32'h0);
        tick();
        check("midrst_idle_valid", wt_valid, 1'b0);
        check("midrst_idle_busy", busy, 1'b0);

        // Scheduler still works after the reset
        do_load(abc_blk, 1'b0);
        walk(0, 20, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/message_scheduler.md
# message_scheduler

Upstream stage of the SHA-256 compression core. It captures one 512-bit padded message block and produces the 64 schedule words W0..W63 one at a time. Each word is handed over on a valid/next handshake and feeds the compressor's Wt input. Words W16..W63 are generated in place in a 16-word circular buffer through a single shared 32-bit adder.

## Interface
Parameters:
- none (SHA-256 word width 32 and round count 64 are fixed)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset; one clock only
- load  in  1  capture block_in and restart schedule at t=0
- block_in  in  512  message block; W0 = [511:480], W15 = [31:0]
- next  in  1  consumer has used current word; advance t
- wt_out  out  32  current schedule word W_t; meaningful only while wt_valid=1
- wt_valid  out  1  wt_out holds W_t for t = t_index
- t_index  out  6  index of the current word
- busy  out  1  block loaded and schedule not finished
- done  out  1  one-cycle pulse after W63 is consumed

## Operation
- Buffer: W[0:15] holds 32-bit words. W_n lives in slot n mod 16.
- wt_out = W[t_index[3:0]], read combinationally.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- All additions are mod 2^32; carries are discarded.
- State IDLE:
  - wt_valid=0, busy=0.
  - load → LOAD.
- State LOAD:
  - Write the 16 words into the buffer, set t=0, busy=1.
  - → READY.
- State READY:
  - wt_valid=1.
  - next with t<15: t←t+1, stay in READY. No computation needed.
  - next with 15≤t<63: n=t+1 → CALC1.
  - next with t=63 → DONE.
- State CALC1: acc ← σ1(W[(n-2)%16]) + W[(n-7)%16].
- State CALC2: acc ← acc + σ0(W[(n-15)%16]).
- State CALC3:
  - W[n%16] ← acc + W[n%16]. This overwrites W_{n-16}, read in the same cycle.
  - t ← n → READY.
- State DONE:
  - done=1, busy←0, wt_valid=0.
  - → IDLE.
- In CALC1..3 and DONE, wt_valid=0.
- Adder operand muxing is selected by state only. The adder is never used outside CALC1..3.
- Precedence:
  - load is accepted in any state and always restarts at LOAD, discarding any in-progress calculation.
  - load and next in the same cycle: load wins.
- next while wt_valid=0 is ignored and is not queued.

## Timing
- Reset values: wt_out=W[0] of a zeroed buffer (0x00000000), wt_valid=0, t_index=0, busy=0, done=0. The buffer and acc are cleared to 0.
- Load latency: load sampled at edge k → wt_valid=1, t_index=0 from edge k+2 (one cycle in LOAD).
- Words 1..15: next at edge k → new word valid at edge k+1 with no bubble.
- Words 16..63: next at edge k → wt_valid low for 3 cycles, new word valid from edge k+4.
- Total throughput for one block: 64 words in 16 + 48×4 cycles of READY/CALC.
- done: next at t=63 on edge k → done high during cycle k+1 only, then IDLE.
- rst_n low at any edge, mid-calculation included → all registers take their reset values at that edge. No partial word is ever exposed.

## Configuration
- Macro: MSG_SCHED_BYTE_SWAP_EN.
- Defined: each 32-bit word of block_in is byte-reversed at LOAD, for a little-endian bus. For example, input word 0x80636261 is stored as W=0x61626380.
- Undefined: words are stored as given (big-endian, FIPS 180-4 order).
- Only the LOAD write path changes. Timing is identical in both builds.

## Structure
- Shared package sha256_pkg holds:
  - the state encoding: IDLE, LOAD, READY, CALC1, CALC2, CALC3, DONE;
  - the constants WORD_W=32, BLOCK_W=512, NUM_ROUNDS=64, BUF_DEPTH=16.
- One sub-module, sigma_func_schedule:
  - input x;
  - outputs s0 (σ0) and s1 (σ1);
  - purely combinational, instantiated once.
- Reuse the existing adder_32bit for the single shared adder.

## Test plan
- Reset, then idle:
  - wt_valid=0, busy=0, done=0, t_index=0 → wt_out=0x00000000.
- "abc" block (0x61626380, 14 zero words, 0x00000018), build without MSG_SCHED_BYTE_SWAP_EN:
  - W0=0x61626380, W15=0x00000018.
  - W16=0x61626380, W17=0x000f0000, W18=0x7da86405, W19=0x600003c6.
  - Each of W16..W19 is valid exactly 4 cycles after its next.
- All-zero block, next held high continuously:
  - all 64 words = 0x00000000;
  - done pulses once, one cycle after the 64th accepted next;
  - busy falls in the same cycle.
- load asserted during CALC2 of word 20:
  - schedule restarts;
  - t_index=0 and wt_out=new W0 two cycles later;
  - the old acc is never written.
- next during CALC1..3 and next with load in the same cycle:
  - a next while wt_valid=0 is ignored and t_index is unchanged;
  - with load+next, load wins and t_index=0.
- Build with MSG_SCHED_BYTE_SWAP_EN:
  - block_in word 0 = 0x80636261 → W0=0x61626380;
  - the rest of the "abc" vectors match the unswapped build.
